reaction_ctrl: RTL

Top-level sequencer for the reaction timer. Holds the millisecond clock divider in reset while idle, waits a pseudo-random delay after a start request, lights the stimulus LED, and counts divider milliseconds until the user reacts. Detects early presses and timeouts. Sits between the debounced button inputs, the ClkDiv instance (drives its DivRst, consumes its ClkMS), and the display logic (ReactMs and status flags).

---
 rtl/reaction_ctrl.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/reaction_ctrl.sv
// Reaction timer sequencer: random pre-stimulus delay, LED stimulus, millisecond
// reaction count, with early-press and timeout detection. All outputs registered.
module reaction_ctrl #(
  parameter int MinDelayMs = 1000,
  parameter int RandBits   = 11,
  parameter int TimeoutMs  = 9999,
  parameter int CountW     = 14
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              react,
  input  logic              clk_ms,
  output logic              div_rst,
  output logic              led_on,
  output logic [CountW-1:0] react_ms,
  output logic              valid,
  output logic              early,
  output logic              timeout
);

  localparam int DelayW = $clog2(MinDelayMs + (1 << RandBits));

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ARMED,
    ST_DONE,
    ST_EARLY,
    ST_TIMEOUT
  } state_t;

  state_t            state;
  state_t            state_next;
  logic [15:0]       lfsr;
  logic              prev;
  logic              tick;
  logic [DelayW-1:0] delay_cnt;
  logic              div_rst_next;
  logic              led_on_next;
  logic              valid_next;
  logic              early_next;
  logic              timeout_next;

  // The divider output idles at 0 while held in reset, so prev follows suit.
  assign tick = (clk_ms ^ prev) & ~div_rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr <= 16'hACE1;
      prev <= 1'b0;
    end else begin
      lfsr <= {lfsr[0] ^ lfsr[2] ^ lfsr[3] ^ lfsr[5], lfsr[15:1]};
      prev <= div_rst ? 1'b0 : clk_ms;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_IDLE, ST_DONE, ST_EARLY, ST_TIMEOUT: begin
        if (start) begin
          state_next = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (react) begin
          state_next = ST_EARLY;
        end else if (tick && (delay_cnt == DelayW'(1))) begin
          state_next = ST_ARMED;
        end
      end
      ST_ARMED: begin
        if (react) begin
          state_next = ST_DONE;
        end else if (tick && (react_ms == CountW'(TimeoutMs - 1))) begin
          state_next = ST_TIMEOUT;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Outputs are decoded from the upcoming state so they can be registered.
  // The first ARMED cycle pulses the divider reset to re-phase it to the LED.
  always_comb begin
    div_rst_next = 1'b1;
    led_on_next  = 1'b0;
    valid_next   = 1'b0;
    early_next   = 1'b0;
    timeout_next = 1'b0;
    case (state_next)
      ST_WAIT: begin
        div_rst_next = 1'b0;
      end
      ST_ARMED: begin
        led_on_next  = 1'b1;
        div_rst_next = (state != ST_ARMED);
      end
      ST_DONE: begin
        valid_next = 1'b1;
      end
      ST_EARLY: begin
        early_next = 1'b1;
      end
      ST_TIMEOUT: begin
        timeout_next = 1'b1;
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      div_rst   <= 1'b1;
      led_on    <= 1'b0;
      valid     <= 1'b0;
      early     <= 1'b0;
      timeout   <= 1'b0;
      react_ms  <= '0;
      delay_cnt <= '0;
    end else begin
      div_rst <= div_rst_next;
      led_on  <= led_on_next;
      valid   <= valid_next;
      early   <= early_next;
      timeout <= timeout_next;

      if ((state_next == ST_WAIT) && (state != ST_WAIT)) begin
        delay_cnt <= DelayW'(MinDelayMs) + DelayW'(lfsr[RandBits-1:0]);
      end else if ((state == ST_WAIT) && (state_next == ST_WAIT) && tick) begin
        delay_cnt <= delay_cnt - DelayW'(1);
      end

      // A React coinciding with a tick freezes the count before the increment.
      if ((state == ST_WAIT) && (state_next == ST_ARMED)) begin
        react_ms <= '0;
      end else if ((state == ST_ARMED) && !react && tick) begin
        react_ms <= react_ms + CountW'(1);
      end
    end
  end

endmodule
